// File: rtl/icache_linefill_assembler.sv
// Assembles downstream read-data beats into full icache lines for the data-array linefill port.
// Two line slots let the next line assemble while the previous one waits for the consumer.
module icache_linefill_assembler #(
  parameter int BEAT_WIDTH      = 128,
  parameter int LINE_WIDTH      = 512,
  parameter int BEATS           = LINE_WIDTH / BEAT_WIDTH,
  parameter int ENTRY_IDX_WIDTH = 4,
  parameter int TXNID_WIDTH     = 8,
  parameter int OPCODE_WIDTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       beat_vld,
  output logic                       beat_rdy,
  input  logic [BEAT_WIDTH-1:0]      beat_data,
  input  logic [ENTRY_IDX_WIDTH-1:0] beat_entry_idx,
  input  logic [TXNID_WIDTH-1:0]     beat_txnid,
  input  logic [OPCODE_WIDTH-1:0]    beat_opcode,
  input  logic                       beat_last,
  output logic                       line_vld,
  input  logic                       line_rdy,
  output logic [LINE_WIDTH-1:0]      line_data,
  output logic [ENTRY_IDX_WIDTH-1:0] line_entry_idx,
  output logic [TXNID_WIDTH-1:0]     line_txnid,
  output logic [OPCODE_WIDTH-1:0]    line_opcode,
  output logic                       err_pulse
);

  localparam int BCNT_WIDTH = $clog2(BEATS);
  localparam logic [BCNT_WIDTH-1:0] LAST_BCNT = BCNT_WIDTH'(BEATS - 1);

  logic [LINE_WIDTH-1:0]      slot_data  [2];
  logic [ENTRY_IDX_WIDTH-1:0] slot_entry [2];
  logic [TXNID_WIDTH-1:0]     slot_txnid [2];
  logic [OPCODE_WIDTH-1:0]    slot_opcode[2];

  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;
  logic [BCNT_WIDTH-1:0] bcnt;

  logic beat_acc;
  logic commit;
  logic pop;
  logic entry_err;
  logic last_err;

  assign beat_rdy  = (cnt != 2'd2);
  assign line_vld  = (cnt != 2'd0);
  assign beat_acc  = beat_vld && beat_rdy;
  assign commit    = beat_acc && (bcnt == LAST_BCNT);
  assign pop       = line_vld && line_rdy;
  assign entry_err = (bcnt != '0) && (beat_entry_idx != slot_entry[wr_ptr]);
  assign last_err  = beat_last != (bcnt == LAST_BCNT);

  // Slot storage carries no reset; anything stale is hidden by cnt gating on the outputs.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      for (int k = 0; k < BEATS; k++) begin
        if (bcnt == BCNT_WIDTH'(k)) begin
          slot_data[wr_ptr][k*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
        end
      end
      if (bcnt == '0) begin
        slot_entry[wr_ptr]  <= beat_entry_idx;
        slot_txnid[wr_ptr]  <= beat_txnid;
        slot_opcode[wr_ptr] <= beat_opcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 2'd0;
      bcnt      <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= beat_acc && (entry_err || last_err);
      if (beat_acc) begin
        bcnt <= bcnt + 1'b1;
      end
      if (commit) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({commit, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    line_data      = '0;
    line_entry_idx = '0;
    line_txnid     = '0;
    line_opcode    = '0;
    if (line_vld) begin
      line_data      = slot_data[rd_ptr];
      line_entry_idx = slot_entry[rd_ptr];
      line_txnid     = slot_txnid[rd_ptr];
      line_opcode    = slot_opcode[rd_ptr];
    end
  end

endmodule

// File: tb/tb_icache_linefill_assembler.sv
// Directed bench for icache_linefill_assembler: driver pushes expected lines into a
// scoreboard queue, a negedge monitor pops and compares on each line handshake.
module tb_icache_linefill_assembler;

  localparam int LW = 512 + 4 + 8 + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         beat_vld = 1'b0;
  logic         beat_rdy;
  logic [127:0] beat_data = '0;
  logic [3:0]   beat_entry_idx = '0;
  logic [7:0]   beat_txnid = '0;
  logic [1:0]   beat_opcode = '0;
  logic         beat_last = 1'b0;
  logic         line_vld;
  logic         line_rdy;
  logic [511:0] line_data;
  logic [3:0]   line_entry_idx;
  logic [7:0]   line_txnid;
  logic [1:0]   line_opcode;
  logic         err_pulse;

  logic line_rdy_man = 1'b1;
  logic rr_mode = 1'b0;
  logic rr_q = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int beats_sent = 0;

  logic [LW-1:0] sb[$];
  logic [LW-1:0] hold_val;
  logic          hold_chk = 1'b0;

  assign line_rdy = rr_mode ? rr_q : line_rdy_man;

  icache_linefill_assembler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .beat_vld       (beat_vld),
    .beat_rdy       (beat_rdy),
    .beat_data      (beat_data),
    .beat_entry_idx (beat_entry_idx),
    .beat_txnid     (beat_txnid),
    .beat_opcode    (beat_opcode),
    .beat_last      (beat_last),
    .line_vld       (line_vld),
    .line_rdy       (line_rdy),
    .line_data      (line_data),
    .line_entry_idx (line_entry_idx),
    .line_txnid     (line_txnid),
    .line_opcode    (line_opcode),
    .err_pulse      (err_pulse)
  );

  always #5 clk = ~clk;

  // Registered-ready consumer: ready is line_vld delayed by one cycle.
  always @(posedge clk) rr_q <= line_vld;

  function automatic logic [127:0] pat(input logic [3:0] n);
    return {32{n}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares presented lines against the scoreboard and checks hold stability.
  always @(negedge clk) begin
    logic [LW-1:0] act;
    logic [LW-1:0] exp;
    act = {line_data, line_entry_idx, line_txnid, line_opcode};
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        vectors++;
        if (act !== hold_val) begin
          miscompares++;
          $display("FAIL line_hold: got %0h expected %0h", act, hold_val);
        end
      end
      hold_chk = 1'b0;
      if (line_vld && !line_rdy) begin
        hold_chk = 1'b1;
        hold_val = act;
      end
      if (line_vld && line_rdy) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL line_unexpected: got %0h expected none", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            miscompares++;
            $display("FAIL line_compare: got %0h expected %0h", act, exp);
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic [3:0] e, input logic [7:0] t,
                           input logic [1:0] op, input logic last, input logic exp_err);
    int waitc;
    waitc = 0;
    @(negedge clk);
    beat_vld = 1'b1;
    beat_data = d;
    beat_entry_idx = e;
    beat_txnid = t;
    beat_opcode = op;
    beat_last = last;
    while (!beat_rdy && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (!beat_rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_accept_timeout: got beat_rdy 0 expected 1");
      beat_vld = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      beat_vld = 1'b0;
      beats_sent++;
      check("err_pulse", 64'(err_pulse), 64'(exp_err));
    end
  endtask

  task automatic send_line(input logic [3:0] base, input logic [3:0] e, input logic [7:0] t,
                           input logic [1:0] op);
    sb.push_back({pat(base + 4'd3), pat(base + 4'd2), pat(base + 4'd1), pat(base), e, t, op});
    for (int k = 0; k < 4; k++) begin
      send_beat(pat(base + 4'(k)), e, t, op, k == 3, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    int waitc;
    waitc = 0;
    while (sb.size() != 0 && waitc < 300) begin
      @(posedge clk);
      waitc++;
    end
    #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    repeat (2) @(posedge clk);
    #1;
    check("reset_line_vld", 64'(line_vld), 64'd0);
    check("reset_beat_rdy", 64'(beat_rdy), 64'd1);
    check("reset_err", 64'(err_pulse), 64'd0);
    check("reset_line_data", 64'(line_data[63:0]), 64'd0);
    rst_n = 1'b1;

    // Single line with latency check
    sb.push_back({pat(4'h3), pat(4'h2), pat(4'h1), pat(4'h0), 4'd3, 8'h15, 2'd1});
    send_beat(pat(4'h0), 4'd3, 8'h15, 2'd1, 1'b0, 1'b0);
    send_beat(pat(4'h1), 4'd3, 8'h15, 2'd1, 1'b0, 1'b0);
    send_beat(pat(4'h2), 4'd3, 8'h15, 2'd1, 1'b0, 1'b0);
    check("vld_before_last", 64'(line_vld), 64'd0);
    send_beat(pat(4'h3), 4'd3, 8'h15, 2'd1, 1'b1, 1'b0);
    check("vld_after_last", 64'(line_vld), 64'd1);
    drain("single_drain");

    // Back-pressure: three lines with consumer stalled
    line_rdy_man = 1'b0;
    beats_sent = 0;
    fork
      begin
        send_line(4'h4, 4'd1, 8'h21, 2'd0);
        send_line(4'h8, 4'd2, 8'h22, 2'd2);
        send_line(4'hc, 4'd6, 8'h23, 2'd3);
      end
      begin
        waitc = 0;
        while (beats_sent < 8 && waitc < 100) begin
          @(posedge clk);
          waitc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("full_beat_rdy", 64'(beat_rdy), 64'd0);
        check("full_line_vld", 64'(line_vld), 64'd1);
        line_rdy_man = 1'b1;
        @(posedge clk);
        #1;
        check("beat_rdy_after_pop", 64'(beat_rdy), 64'd1);
      end
    join
    drain("bp_drain");

    // Registered-ready consumer
    rr_mode = 1'b1;
    send_line(4'h1, 4'd9, 8'h31, 2'd1);
    send_line(4'h5, 4'd10, 8'h32, 2'd2);
    drain("rr_drain");
    rr_mode = 1'b0;

    // Commit of B and pop of A on the same edge
    line_rdy_man = 1'b0;
    send_line(4'h2, 4'd4, 8'h41, 2'd0);
    sb.push_back({pat(4'h9), pat(4'h8), pat(4'h7), pat(4'h6), 4'd7, 8'h42, 2'd3});
    send_beat(pat(4'h6), 4'd7, 8'h42, 2'd3, 1'b0, 1'b0);
    send_beat(pat(4'h7), 4'd7, 8'h42, 2'd3, 1'b0, 1'b0);
    send_beat(pat(4'h8), 4'd7, 8'h42, 2'd3, 1'b0, 1'b0);
    line_rdy_man = 1'b1;
    send_beat(pat(4'h9), 4'd7, 8'h42, 2'd3, 1'b1, 1'b0);
    line_rdy_man = 1'b0;
    check("simul_line_vld", 64'(line_vld), 64'd1);
    check("simul_beat_rdy", 64'(beat_rdy), 64'd1);
    check("simul_entry", 64'(line_entry_idx), 64'd7);
    @(posedge clk);
    #1;
    line_rdy_man = 1'b1;
    drain("simul_drain");

    // Protocol errors: entry mismatch, then early beat_last
    sb.push_back({pat(4'hd), pat(4'hc), pat(4'hb), pat(4'ha), 4'd3, 8'h51, 2'd1});
    send_beat(pat(4'ha), 4'd3, 8'h51, 2'd1, 1'b0, 1'b0);
    send_beat(pat(4'hb), 4'd3, 8'h51, 2'd1, 1'b0, 1'b0);
    send_beat(pat(4'hc), 4'd5, 8'h51, 2'd1, 1'b0, 1'b1);
    send_beat(pat(4'hd), 4'd3, 8'h51, 2'd1, 1'b1, 1'b0);
    drain("err_entry_drain");
    sb.push_back({pat(4'h3), pat(4'h2), pat(4'h1), pat(4'h0), 4'd8, 8'h52, 2'd2});
    send_beat(pat(4'h0), 4'd8, 8'h52, 2'd2, 1'b0, 1'b0);
    send_beat(pat(4'h1), 4'd8, 8'h52, 2'd2, 1'b1, 1'b1);
    send_beat(pat(4'h2), 4'd8, 8'h52, 2'd2, 1'b0, 1'b0);
    check("early_last_no_commit", 64'(line_vld), 64'd0);
    send_beat(pat(4'h3), 4'd8, 8'h52, 2'd2, 1'b1, 1'b0);
    drain("err_last_drain");

    // Reset mid-line
    send_beat(pat(4'hf), 4'd2, 8'h61, 2'd0, 1'b0, 1'b0);
    send_beat(pat(4'he), 4'd2, 8'h61, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_line_vld", 64'(line_vld), 64'd0);
    check("rst_mid_beat_rdy", 64'(beat_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_line(4'h6, 4'd11, 8'h62, 2'd3);
    drain("post_reset_drain");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_linefill_assembler.md
# icache_linefill_assembler

Collects narrow read-data beats returned by the downstream memory interface, assembles them into full 512-bit cache lines, and presents each completed line with its MSHR entry index, txnid and opcode to the icache data-array controller's linefill input. A 2-slot line buffer lets the next line assemble while the previous one waits for the registered-ready handshake of the data-array controller. The block is purely datapath/handshake: it does not touch tag or data RAMs.

## Interface
- BEAT_WIDTH, 128, width of one downstream data beat
- LINE_WIDTH, 512, cache line width (equals ICACHE_DATA_WIDTH)
- BEATS, LINE_WIDTH/BEAT_WIDTH (4), beats per line; must be a power of two ≥2
- ENTRY_IDX_WIDTH, MSHR_ENTRY_INDEX_WIDTH, MSHR entry index width
- TXNID_WIDTH, ICACHE_REQ_TXNID_WIDTH, request txnid width
- OPCODE_WIDTH, 2, response opcode width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- beat_vld  in  1  downstream beat valid
- beat_rdy  out  1  beat accepted when beat_vld && beat_rdy
- beat_data  in  BEAT_WIDTH  beat payload
- beat_entry_idx  in  ENTRY_IDX_WIDTH  MSHR entry the beat belongs to
- beat_txnid  in  TXNID_WIDTH  originating request txnid
- beat_opcode  in  OPCODE_WIDTH  response opcode
- beat_last  in  1  downstream marks final beat of line
- line_vld  out  1  assembled line available
- line_rdy  in  1  consumer accepts line when line_vld && line_rdy
- line_data  out  LINE_WIDTH  assembled line, beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
- line_entry_idx  out  ENTRY_IDX_WIDTH  entry index latched from beat 0
- line_txnid  out  TXNID_WIDTH  txnid latched from beat 0
- line_opcode  out  OPCODE_WIDTH  opcode latched from beat 0
- err_pulse  out  1  one-cycle protocol-error flag

## Operation
- Storage: 2 line slots (data + header), wr_ptr, rd_ptr (1 bit each), occupancy cnt (0..2), beat counter bcnt (log2(BEATS) bits).
- beat_rdy = (cnt != 2); combinational from registered state only.
- Accepted beat writes beat_data into slot[wr_ptr] at position bcnt; bcnt increments, wrapping BEATS-1 → 0.
- bcnt==0 beat: latch entry_idx, txnid, opcode into slot[wr_ptr] header.
- bcnt==BEATS-1 beat: commit — wr_ptr toggles, cnt increments.
- Beats of one line are contiguous; no interleaving across entries.
- Error checks on an accepted beat (err_pulse high the following cycle, one cycle per offending beat):
  - bcnt != 0 and beat_entry_idx != latched header entry_idx;
  - beat_last != (bcnt == BEATS-1).
- Errors do not alter behaviour: the beat is still stored, header unchanged, commit strictly by bcnt.
- Output: line_vld = (cnt != 0); line_* = slot[rd_ptr]; all line_* outputs forced to 0 when line_vld=0.
- Pop on line_vld && line_rdy: rd_ptr toggles, cnt decrements.
- Commit and pop in same cycle: cnt unchanged, both pointers toggle.
- line_vld/line_* held stable until accepted; the consumer may assert line_rdy a cycle late (registered ready) — no data is lost.

## Timing
- Reset values: cnt=0, bcnt=0, wr_ptr=rd_ptr=0, line_vld=0, line_* =0, err_pulse=0, beat_rdy=1.
- Reset mid-line: partial line discarded; next beat after reset treated as beat 0.
- Latency: line_vld rises the cycle after the last beat is accepted.
- Throughput: 1 beat/cycle; sustained BEATS cycles per line when line_rdy keeps up.
- Full: with 2 lines pending, beat_rdy=0; it rises the cycle after a pop.
- Slot data registers need no reset; header/outputs gated by cnt.

## Test plan
- Single line: 4 beats 0x0..0,0x1..1,0x2..2,0x3..3, entry 3, txnid 0x15, last on beat 3, line_rdy=1 → line_vld one cycle after beat 3, line_data = {beat3,beat2,beat1,beat0}, entry 3, txnid 0x15, err_pulse never high.
- Back-pressure: line_rdy=0, send 3 lines back-to-back → first two lines buffered, beat_rdy=0 after 8th beat; raise line_rdy → lines emerge in order, beat_rdy returns 1 the cycle after first pop, third line completes.
- Registered-ready consumer: line_rdy = line_vld delayed one cycle → each line held 2 cycles, accepted exactly once, outputs stable while waiting.
- Simultaneous commit and pop: last beat of line B accepted in same cycle line A popped → cnt stays 1, line B presented next cycle.
- Protocol errors: beat 2 with entry 5 on a line started with entry 3 → err_pulse one cycle, line header entry 3; beat_last on beat 1 → err_pulse, line still commits after beat 3.
- Reset mid-line: assert rst_n=0 after 2 beats → line_vld=0, beat_rdy=1; fresh 4-beat line after reset assembles correctly with no stale data.
